// File: rtl/simd_mac_pkg.sv
// simd_mac_pkg
// Shared types and lane geometry for the post-multiply accumulate stage.
//   - MAC_* localparams : default lane geometry; the stage's parameters
//                         default to these so the stage-1 struct lines up
//   - SEW_IDX_*         : bit positions inside the one-hot SEW select
//   - mac_op_t          : accumulate operation after opcode decode
//   - mac_s1_t          : everything captured at issue, waiting for the product
package simd_mac_pkg;

   localparam int MAC_MIN_WIDTH = 8;
   localparam int MAC_MAX_WIDTH = 64;
   localparam int MAC_SEW_WIDTH = $clog2(MAC_MAX_WIDTH / MAC_MIN_WIDTH) + 1;
   localparam int MAC_TAG_WIDTH = 5;

   // Bit 0 of the one-hot SEW selects full-width elements, the top bit the
   // narrowest elements.
   localparam int SEW_IDX_MAX = 0;
   localparam int SEW_IDX_MIN = MAC_SEW_WIDTH - 1;

   typedef enum logic [1:0] {
      MAC_PASS = 2'b00,
      MAC_ADD  = 2'b01,
      MAC_SUB  = 2'b10
   } mac_op_t;

   typedef struct packed {
      mac_op_t                    op;
      logic [MAC_SEW_WIDTH-1:0]   sew;
      logic [MAC_MAX_WIDTH-1:0]   acc;
      logic [MAC_TAG_WIDTH-1:0]   tag;
   } mac_s1_t;

   // The reserved encoding 2'b11 behaves like a plain product pass-through.
   function automatic mac_op_t decode_op(input logic [1:0] raw);
      mac_op_t op;
      case (raw)
         2'b01:   op = MAC_ADD;
         2'b10:   op = MAC_SUB;
         default: op = MAC_PASS;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/simd_add.sv
// simd_add
// Combinational SEW-segmented adder/subtractor. The lane is split into
// MIN_WIDTH-bit segments; a carry is allowed to ripple from one segment into
// the next only when both belong to the same element at the selected SEW.
// Subtraction is a + ~b + 1 with the +1 injected at the base of every element.
// Ports:
//   a    in  MAX_WIDTH  minuend / addend
//   b    in  MAX_WIDTH  subtrahend / addend
//   sub  in  1          1 = a - b, 0 = a + b
//   sew  in  SEW_W      one-hot element width (bit 0 = MAX_WIDTH)
//   sum  out MAX_WIDTH  per-element result, modulo 2^SEW
module simd_add
   import simd_mac_pkg::*;
#(
   parameter int MIN_WIDTH = MAC_MIN_WIDTH,
   parameter int MAX_WIDTH = MAC_MAX_WIDTH
)(
   input  logic [MAX_WIDTH-1:0]                             a,
   input  logic [MAX_WIDTH-1:0]                             b,
   input  logic                                             sub,
   input  logic [$clog2(MAX_WIDTH/MIN_WIDTH):0]             sew,
   output logic [MAX_WIDTH-1:0]                             sum
);

   localparam int NSEG  = MAX_WIDTH / MIN_WIDTH;
   localparam int SEW_W = $clog2(MAX_WIDTH / MIN_WIDTH) + 1;

   logic [NSEG-1:0]      seg_start;
   logic [MAX_WIDTH-1:0] b_eff;

   // A segment starts a new element when its index is a multiple of the
   // element size (in segments) for the selected SEW. Segment 0 always
   // starts an element so a malformed (all-zero) SEW still subtracts sanely.
   for (genvar i = 0; i < NSEG; i++) begin : g_seg
      logic [SEW_W-1:0] hit;
      for (genvar k = SEW_IDX_MAX; k <= SEW_IDX_MIN; k++) begin : g_k
         assign hit[k] = sew[k] & ((i % ((MAX_WIDTH >> k) / MIN_WIDTH)) == 0);
      end
      assign seg_start[i] = (i == 0) | (|hit);
   end

   assign b_eff = sub ? ~b : b;

   // Ripple one segment at a time; at an element boundary the incoming carry
   // is replaced by the subtract flag, which both cuts the chain and supplies
   // the two's-complement +1.
   always_comb begin : p_ripple
      logic             carry;
      logic [MIN_WIDTH:0] seg_sum;
      sum     = '0;
      carry   = 1'b0;
      seg_sum = '0;
      for (int i = 0; i < NSEG; i++) begin
         if (seg_start[i]) begin
            carry = sub;
         end
         seg_sum = {1'b0, a[i*MIN_WIDTH +: MIN_WIDTH]}
                 + {1'b0, b_eff[i*MIN_WIDTH +: MIN_WIDTH]}
                 + {{MIN_WIDTH{1'b0}}, carry};
         sum[i*MIN_WIDTH +: MIN_WIDTH] = seg_sum[MIN_WIDTH-1:0];
         carry = seg_sum[MIN_WIDTH];
      end
   end

endmodule

// File: rtl/simd_mac_stage.sv
// simd_mac_stage
// Accumulate stage directly behind the lane's SIMD multiplier. An issue is
// accepted in the cycle the multiplier samples its operands; the product
// arrives one cycle later, is combined with the captured accumulator operand
// (pass / add / subtract, segmented by SEW) and written into a small FIFO.
// The multiplier cannot stall, so issue is gated by a credit counter that
// reserves a FIFO slot for every accepted issue.
// Optional feature macro: SIMD_MAC_FLUSH_EN adds flush_i, which discards all
// in-flight and buffered results and restores full credit.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush_i             (SIMD_MAC_FLUSH_EN only) discard everything
//   valid_i / ready_o   issue handshake
//   op_i, sew_i         operation and one-hot element width
//   acc_i, tag_i        accumulator operand and opaque tag, sampled at issue
//   prod_i              multiplier product, valid one cycle after issue
//   valid_o / ready_i   result handshake
//   result_o, tag_o, sew_o  registered head-of-FIFO result
module simd_mac_stage
   import simd_mac_pkg::*;
#(
   parameter int MIN_WIDTH = MAC_MIN_WIDTH,
   parameter int MAX_WIDTH = MAC_MAX_WIDTH,
   parameter int SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1,
   parameter int TAG_WIDTH = MAC_TAG_WIDTH,
   parameter int DEPTH     = 4
)(
   input  logic                  clk,
   input  logic                  rst,
`ifdef SIMD_MAC_FLUSH_EN
   input  logic                  flush_i,
`endif
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [1:0]            op_i,
   input  logic [SEW_WIDTH-1:0]  sew_i,
   input  logic [MAX_WIDTH-1:0]  acc_i,
   input  logic [TAG_WIDTH-1:0]  tag_i,
   input  logic [MAX_WIDTH-1:0]  prod_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [MAX_WIDTH-1:0]  result_o,
   output logic [TAG_WIDTH-1:0]  tag_o,
   output logic [SEW_WIDTH-1:0]  sew_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CREDIT = CNT_W'(DEPTH);

   logic                 flush;
   logic [CNT_W-1:0]     credits;
   logic                 accept;
   logic                 pop;

   logic                 s1_valid;
   mac_s1_t              s1;

   logic [MAX_WIDTH-1:0] add_sum;
   logic [MAX_WIDTH-1:0] wr_result;
   logic                 wr;

   logic [MAX_WIDTH-1:0] mem_result [DEPTH];
   logic [TAG_WIDTH-1:0] mem_tag    [DEPTH];
   logic [SEW_WIDTH-1:0] mem_sew    [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     rd_ptr_n;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     count_n;

`ifdef SIMD_MAC_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif

   // Credits count FIFO slots not yet promised to an issue, so they also
   // cover the entry sitting in stage 1. Readiness never looks at valid_i.
   assign ready_o = (credits != '0) && !flush;
   assign accept  = valid_i && ready_o;
   assign pop     = valid_o && ready_i && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits <= FULL_CREDIT;
      end else if (flush) begin
         credits <= FULL_CREDIT;
      end else begin
         case ({accept, pop})
            2'b10:   credits <= credits - CNT_W'(1);
            2'b01:   credits <= credits + CNT_W'(1);
            default: credits <= credits;
         endcase
      end
   end

   // Stage 1 holds the issue-time operands until the product shows up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1 <= '{op: decode_op(op_i), sew: sew_i, acc: acc_i, tag: tag_i};
         end
      end
   end

   simd_add #(
      .MIN_WIDTH (MIN_WIDTH),
      .MAX_WIDTH (MAX_WIDTH)
   ) u_add (
      .a   (s1.acc),
      .b   (prod_i),
      .sub (s1.op == MAC_SUB),
      .sew (s1.sew),
      .sum (add_sum)
   );

   // Stage 2 always writes when stage 1 is occupied: the credit taken at
   // issue guarantees a free slot. A flush drops the in-flight entry.
   assign wr        = s1_valid && !flush;
   assign wr_result = (s1.op == MAC_PASS) ? prod_i : add_sum;

   assign rd_ptr_n = rd_ptr + PTR_W'(pop);
   assign count_n  = count + CNT_W'(wr) - CNT_W'(pop);

   always_ff @(posedge clk) begin
      if (wr) begin
         mem_result[wr_ptr] <= wr_result;
         mem_tag[wr_ptr]    <= s1.tag;
         mem_sew[wr_ptr]    <= s1.sew;
      end
   end

   // The output registers mirror the entry that will be at the head after
   // this edge. When that entry is the one being written right now it is
   // taken from the write data, which is what lets an empty FIFO present a
   // result the cycle after the write. Only a pop moves the head, so the
   // outputs hold while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         valid_o  <= 1'b0;
         result_o <= '0;
         tag_o    <= '0;
         sew_o    <= '0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         valid_o  <= 1'b0;
      end else begin
         wr_ptr  <= wr_ptr + PTR_W'(wr);
         rd_ptr  <= rd_ptr_n;
         count   <= count_n;
         valid_o <= (count_n != '0);
         if (count_n != '0) begin
            if (wr && (wr_ptr == rd_ptr_n)) begin
               result_o <= wr_result;
               tag_o    <= s1.tag;
               sew_o    <= s1.sew;
            end else begin
               result_o <= mem_result[rd_ptr_n];
               tag_o    <= mem_tag[rd_ptr_n];
               sew_o    <= mem_sew[rd_ptr_n];
            end
         end
      end
   end

endmodule
